// File: rtl/mips_pkg.sv
// mips_pkg: shared MIPS encodings, FSM state type, decoded control struct
// and the ALU_CONTROLLER mapping used by the multi-cycle control unit.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_BLEZ   = 6'h06;
    localparam logic [5:0] OP_BGTZ   = 6'h07;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_ADDIU  = 6'h09;
    localparam logic [5:0] OP_SLTI   = 6'h0a;
    localparam logic [5:0] OP_SLTIU  = 6'h0b;
    localparam logic [5:0] OP_ANDI   = 6'h0c;
    localparam logic [5:0] OP_ORI    = 6'h0d;
    localparam logic [5:0] OP_XORI   = 6'h0e;
    localparam logic [5:0] OP_LUI    = 6'h0f;
    localparam logic [5:0] OP_LB     = 6'h20;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_SB     = 6'h28;
    localparam logic [5:0] OP_SW     = 6'h2b;

    localparam logic [5:0] F_SLL     = 6'h00;
    localparam logic [5:0] F_SRL     = 6'h02;
    localparam logic [5:0] F_SRA     = 6'h03;
    localparam logic [5:0] F_JR      = 6'h08;
    localparam logic [5:0] F_SYSCALL = 6'h0c;
    localparam logic [5:0] F_MULT    = 6'h18;
    localparam logic [5:0] F_MULTU   = 6'h19;
    localparam logic [5:0] F_DIV     = 6'h1a;
    localparam logic [5:0] F_DIVU    = 6'h1b;
    localparam logic [5:0] F_ADD     = 6'h20;
    localparam logic [5:0] F_ADDU    = 6'h21;
    localparam logic [5:0] F_SUB     = 6'h22;
    localparam logic [5:0] F_SUBU    = 6'h23;
    localparam logic [5:0] F_AND     = 6'h24;
    localparam logic [5:0] F_OR      = 6'h25;
    localparam logic [5:0] F_XOR     = 6'h26;
    localparam logic [5:0] F_NOR     = 6'h27;
    localparam logic [5:0] F_SLT     = 6'h2a;
    localparam logic [5:0] F_SLTU    = 6'h2b;

    // REGIMM rt field selecting BGEZ; other REGIMM forms are not supported
    localparam logic [4:0] RT_BGEZ   = 5'd1;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_NOR  = 4'd5;
    localparam logic [3:0] ALU_SLT  = 4'd6;
    localparam logic [3:0] ALU_SLTU = 4'd7;
    localparam logic [3:0] ALU_SLL  = 4'd8;
    localparam logic [3:0] ALU_SRL  = 4'd9;
    localparam logic [3:0] ALU_SRA  = 4'd10;
    localparam logic [3:0] ALU_LUI  = 4'd11;
    localparam logic [3:0] ALU_MUL  = 4'd12;
    localparam logic [3:0] ALU_DIV  = 4'd13;

    typedef enum logic [1:0] {S_EXEC, S_MEM, S_MD, S_HALT} state_t;

    typedef enum logic [2:0] {
        C_ALU, C_BRANCH, C_JUMP, C_LOAD, C_STORE, C_MULDIV, C_SYSCALL, C_ILLEGAL
    } iclass_t;

    // Datapath selects plus the ungated write/redirect intents of an instruction
    typedef struct packed {
        logic alu_src;
        logic reg_dest;
        logic pc_or_mem;
        logic mem_or_reg;
        logic is_unsigned;
        logic does_shift_amount_need;
        logic is_byte;
        logic reg_write;
        logic jump;
        logic jump_register;
    } ctrl_t;

    // ALU_CONTROLLER: (opcode, funct) -> ALU operation; anything unlisted adds
    function automatic logic [3:0] alu_controller(input logic [5:0] opcode, input logic [5:0] funct);
        logic [3:0] op;
        op = ALU_ADD;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    F_SUB, F_SUBU:    op = ALU_SUB;
                    F_AND:            op = ALU_AND;
                    F_OR:             op = ALU_OR;
                    F_XOR:            op = ALU_XOR;
                    F_NOR:            op = ALU_NOR;
                    F_SLT:            op = ALU_SLT;
                    F_SLTU:           op = ALU_SLTU;
                    F_SLL:            op = ALU_SLL;
                    F_SRL:            op = ALU_SRL;
                    F_SRA:            op = ALU_SRA;
                    F_MULT, F_MULTU:  op = ALU_MUL;
                    F_DIV, F_DIVU:    op = ALU_DIV;
                    default:          op = ALU_ADD;
                endcase
            end
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_REGIMM: op = ALU_SUB;
            OP_SLTI:  op = ALU_SLT;
            OP_SLTIU: op = ALU_SLTU;
            OP_ANDI:  op = ALU_AND;
            OP_ORI:   op = ALU_OR;
            OP_XORI:  op = ALU_XOR;
            OP_LUI:   op = ALU_LUI;
            default:  op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/control_decoder.sv
// control_decoder: purely combinational instruction decode.
// Ports:
//   inst  in  32  instruction word
//   ctrl  out     ctrl_t selects and write/redirect intents (all 0 when illegal)
//   cls   out     instruction class driving the sequencer
module control_decoder
    import mips_pkg::*;
#(
    parameter int BYTE_OPS = 1
) (
    input  logic [31:0] inst,
    output ctrl_t       ctrl,
    output iclass_t     cls
);

    logic [5:0] opcode;
    logic [5:0] funct;
    logic [4:0] rt;
    logic       unused_bits;

    assign opcode      = inst[31:26];
    assign rt          = inst[20:16];
    assign funct       = inst[5:0];
    assign unused_bits = ^{inst[25:21], inst[15:6]};

    always_comb begin
        ctrl = '0;
        cls  = C_ILLEGAL;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    F_SLL, F_SRL, F_SRA: begin
                        cls                         = C_ALU;
                        ctrl.reg_dest               = 1'b1;
                        ctrl.reg_write              = 1'b1;
                        ctrl.does_shift_amount_need = 1'b1;
                    end
                    F_ADD, F_SUB, F_AND, F_OR, F_XOR, F_NOR, F_SLT: begin
                        cls            = C_ALU;
                        ctrl.reg_dest  = 1'b1;
                        ctrl.reg_write = 1'b1;
                    end
                    F_ADDU, F_SUBU, F_SLTU: begin
                        cls              = C_ALU;
                        ctrl.reg_dest    = 1'b1;
                        ctrl.reg_write   = 1'b1;
                        ctrl.is_unsigned = 1'b1;
                    end
                    F_JR: begin
                        cls                = C_JUMP;
                        ctrl.jump_register = 1'b1;
                    end
                    // HI/LO result lands through the rd path when the unit finishes
                    F_MULT, F_DIV: begin
                        cls           = C_MULDIV;
                        ctrl.reg_dest = 1'b1;
                    end
                    F_MULTU, F_DIVU: begin
                        cls              = C_MULDIV;
                        ctrl.reg_dest    = 1'b1;
                        ctrl.is_unsigned = 1'b1;
                    end
                    F_SYSCALL: cls = C_SYSCALL;
                    default:   cls = C_ILLEGAL;
                endcase
            end
            OP_REGIMM: cls = (rt == RT_BGEZ) ? C_BRANCH : C_ILLEGAL;
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: cls = C_BRANCH;
            OP_J: begin
                cls       = C_JUMP;
                ctrl.jump = 1'b1;
            end
            OP_JAL: begin
                cls            = C_JUMP;
                ctrl.jump      = 1'b1;
                ctrl.pc_or_mem = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            OP_ADDI, OP_SLTI, OP_LUI: begin
                cls            = C_ALU;
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            OP_ADDIU, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI: begin
                cls              = C_ALU;
                ctrl.alu_src     = 1'b1;
                ctrl.reg_write   = 1'b1;
                ctrl.is_unsigned = 1'b1;
            end
            OP_LW: begin
                cls             = C_LOAD;
                ctrl.alu_src    = 1'b1;
                ctrl.mem_or_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
            end
            OP_SW: begin
                cls          = C_STORE;
                ctrl.alu_src = 1'b1;
            end
            OP_LB: begin
                if (BYTE_OPS != 0) begin
                    cls             = C_LOAD;
                    ctrl.alu_src    = 1'b1;
                    ctrl.mem_or_reg = 1'b1;
                    ctrl.reg_write  = 1'b1;
                    ctrl.is_byte    = 1'b1;
                end
            end
            OP_SB: begin
                if (BYTE_OPS != 0) begin
                    cls          = C_STORE;
                    ctrl.alu_src = 1'b1;
                    ctrl.is_byte = 1'b1;
                end
            end
            default: cls = C_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/mc_control_unit.sv
// mc_control_unit: multi-cycle MIPS control unit. Decodes inst, drives the
// datapath selects, gates architectural writes to the completing cycle and
// sequences stalls for cache misses, iterative MULT/DIV and SYSCALL halt.
// Ports:
//   clk, rst_b                 clock / synchronous active-low reset
//   inst, inst_valid           instruction from fetch (held while pc_we=0)
//   zero, negative             ALU flags for branch resolution
//   hit                        data cache completes the access this cycle
//   alu_operation, selects     datapath control (0 in reset and halt)
//   reg_write_enable, mem_write_en, branch, jump, jump_register  gated strobes
//   pc_we, mem_req, is_byte    fetch / data-cache handshake
//   md_start, md_busy          MULT/DIV launch pulse and busy flag
//   halted, illegal_inst, mem_timeout_err  status
module mc_control_unit
    import mips_pkg::*;
#(
    parameter int MD_LATENCY  = 8,
    parameter int MEM_TIMEOUT = 0,
    parameter int BYTE_OPS    = 1
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic [31:0] inst,
    input  logic        inst_valid,
    input  logic        zero,
    input  logic        negative,
    input  logic        hit,
    output logic [3:0]  alu_operation,
    output logic        alu_src,
    output logic        reg_dest,
    output logic        pc_or_mem,
    output logic        mem_or_reg,
    output logic        is_unsigned,
    output logic        does_shift_amount_need,
    output logic        reg_write_enable,
    output logic        mem_write_en,
    output logic        branch,
    output logic        jump,
    output logic        jump_register,
    output logic        pc_we,
    output logic        mem_req,
    output logic        is_byte,
    output logic        md_start,
    output logic        md_busy,
    output logic        halted,
    output logic        illegal_inst,
    output logic        mem_timeout_err
);

    // One counter serves both the miss timer and the MULT/DIV countdown
    localparam int CNT_MAX = (MD_LATENCY > MEM_TIMEOUT) ? MD_LATENCY : MEM_TIMEOUT;
    localparam int CW      = $clog2(CNT_MAX + 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    ctrl_t         ctrl;
    iclass_t       cls;
    logic [5:0]    opcode;
    logic          sel_en;
    logic          taken;

    control_decoder #(.BYTE_OPS(BYTE_OPS)) u_dec (
        .inst (inst),
        .ctrl (ctrl),
        .cls  (cls)
    );

    assign opcode = inst[31:26];
    assign sel_en = rst_b && (state_q != S_HALT);

    // Only BGEZ decodes as a branch under REGIMM, so the fall-through is !negative
    assign taken = (opcode == OP_BEQ)  ? zero :
                   (opcode == OP_BNE)  ? !zero :
                   (opcode == OP_BLEZ) ? (zero || negative) :
                   (opcode == OP_BGTZ) ? (!zero && !negative) : !negative;

    assign alu_operation          = sel_en ? alu_controller(opcode, inst[5:0]) : 4'd0;
    assign alu_src                = sel_en && ctrl.alu_src;
    assign reg_dest               = sel_en && ctrl.reg_dest;
    assign pc_or_mem              = sel_en && ctrl.pc_or_mem;
    assign mem_or_reg             = sel_en && ctrl.mem_or_reg;
    assign is_unsigned            = sel_en && ctrl.is_unsigned;
    assign does_shift_amount_need = sel_en && ctrl.does_shift_amount_need;
    assign is_byte                = sel_en && ctrl.is_byte;
    assign mem_timeout_err        = rst_b && err_q;

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        err_d            = err_q;
        pc_we            = 1'b0;
        mem_req          = 1'b0;
        md_start         = 1'b0;
        md_busy          = 1'b0;
        halted           = 1'b0;
        illegal_inst     = 1'b0;
        reg_write_enable = 1'b0;
        mem_write_en     = 1'b0;
        branch           = 1'b0;
        jump             = 1'b0;
        jump_register    = 1'b0;
        if (rst_b) begin
            case (state_q)
                S_EXEC: begin
                    if (inst_valid) begin
                        case (cls)
                            C_ALU, C_JUMP: begin
                                reg_write_enable = ctrl.reg_write;
                                jump             = ctrl.jump;
                                jump_register    = ctrl.jump_register;
                                pc_we            = 1'b1;
                            end
                            C_BRANCH: begin
                                branch = taken;
                                pc_we  = 1'b1;
                            end
                            C_LOAD, C_STORE: begin
                                mem_req = 1'b1;
                                if (hit) begin
                                    reg_write_enable = (cls == C_LOAD);
                                    mem_write_en     = (cls == C_STORE);
                                    pc_we            = 1'b1;
                                end else begin
                                    state_d = S_MEM;
                                    cnt_d   = CW'(1);
                                end
                            end
                            C_MULDIV: begin
                                md_start = 1'b1;
                                cnt_d    = CW'(MD_LATENCY - 1);
                                state_d  = S_MD;
                            end
                            C_SYSCALL: begin
                                halted  = 1'b1;
                                state_d = S_HALT;
                            end
                            default: begin
                                illegal_inst = 1'b1;
                                pc_we        = 1'b1;
                            end
                        endcase
                    end
                end
                S_MEM: begin
                    mem_req = 1'b1;
                    // cnt_q is the 1-based index of this miss cycle; hit beats expiry
                    if (hit) begin
                        reg_write_enable = (cls == C_LOAD);
                        mem_write_en     = (cls == C_STORE);
                        pc_we            = 1'b1;
                        state_d          = S_EXEC;
                    end else if (MEM_TIMEOUT != 0 && cnt_q == CW'(MEM_TIMEOUT)) begin
                        err_d   = 1'b1;
                        state_d = S_HALT;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_MD: begin
                    md_busy = 1'b1;
                    if (cnt_q == '0) begin
                        reg_write_enable = 1'b1;
                        pc_we            = 1'b1;
                        state_d          = S_EXEC;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: halted = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state_q <= S_EXEC;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

endmodule
